// File: rtl/serial_to_parallel_lane_if.sv
// Serial lane bundle between the line-side bit source and the deserializer.
//   data_in   : serial bit, MSB of each lane word first
//   lane_out  : last received data word, held between updates
//   valid_out : lane_out holds the word received at the latest boundary
//   active    : lane has achieved word alignment
// master = bit source / downstream consumer side, slave = deserializer side.
interface serial_to_parallel_lane_if #(
  parameter int WIDTH = 32
);
  logic             data_in;
  logic [WIDTH-1:0] lane_out;
  logic             valid_out;
  logic             active;

  modport master (
    output data_in,
    input  lane_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output lane_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_to_parallel_lane.sv
// Per-lane receive deserializer feeding the unstriping stage.
// Shifts in one serial bit per clk_32f edge (MSB first), hunts for the COM
// symbol to find word boundaries, declares lock after ALIGN_COUNT
// consecutive boundary-aligned COM words, then presents data words.
//   clk_32f        : bit clock, all logic in this domain
//   reset          : synchronous, active-high, aborts all progress
//   lane.data_in   : serial input bit
//   lane.lane_out  : last data word (COM/IDLE are never forwarded)
//   lane.valid_out : high for the word period after a data word boundary
//   lane.active    : lane aligned
module serial_to_parallel_lane #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] COM         = 32'hBCBCBCBC,
  parameter logic [WIDTH-1:0] IDLE        = 32'h7C7C7C7C,
  parameter int               ALIGN_COUNT = 4
) (
  input  logic                       clk_32f,
  input  logic                       reset,
  serial_to_parallel_lane_if.slave   lane
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(ALIGN_COUNT + 1);

  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALIGN_COUNT - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // Only the newest WIDTH-1 bits are ever read back (the oldest bit drops
  // out of the candidate word), so the history register is one bit short.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    com_cnt_q, com_cnt_d;
  logic [WIDTH-1:0] lane_out_q, lane_out_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;

  logic [WIDTH-1:0] w;
  logic             boundary;

  always_comb begin
    // Candidate word includes the bit sampled on this edge.
    w          = {sr_q, lane.data_in};
    boundary   = (bit_cnt_q == BIT_LAST);

    sr_d       = w[WIDTH-2:0];
    bit_cnt_d  = bit_cnt_q + BIT_ONE;
    com_cnt_d  = com_cnt_q;
    state_d    = state_q;
    lane_out_d = lane_out_q;
    valid_d    = valid_q;
    active_d   = active_q;

    case (state_q)
      SEARCH: begin
        // Every edge is a potential boundary while hunting.
        if (w == COM) begin
          com_cnt_d = CNT_ONE;
          bit_cnt_d = '0;
          state_d   = LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (w == COM) begin
            com_cnt_d = com_cnt_q + CNT_ONE;
            if (com_cnt_q == CNT_LAST) begin
              state_d  = ALIGNED;
              active_d = 1'b1;
            end
          end else begin
            // A corrupted or shifted COM restarts the hunt from scratch.
            com_cnt_d = '0;
            state_d   = SEARCH;
          end
        end
      end
      ALIGNED: begin
        // Only boundary-aligned words are classified; COM patterns that
        // straddle a boundary inside data are ignored.
        if (boundary) begin
          if ((w == COM) || (w == IDLE)) begin
            valid_d = 1'b0;
          end else begin
            lane_out_d = w;
            valid_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= SEARCH;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      lane_out_q <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      lane_out_q <= lane_out_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
    end
  end

  assign lane.lane_out  = lane_out_q;
  assign lane.valid_out = valid_q;
  assign lane.active    = active_q;

endmodule

// File: tb/tb_serial_to_parallel_lane.sv
module tb_serial_to_parallel_lane;

  localparam logic [31:0] COM  = 32'hBCBCBCBC;
  localparam logic [31:0] IDLE = 32'h7C7C7C7C;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_to_parallel_lane_if #(.WIDTH(32)) lane_if ();

  serial_to_parallel_lane #(
    .WIDTH(32), .COM(COM), .IDLE(IDLE), .ALIGN_COUNT(4)
  ) dut (
    .clk_32f(clk),
    .reset  (reset),
    .lane   (lane_if)
  );

  // {lane_out, valid_out, active}
  logic [33:0] obs;
  assign obs = {lane_if.lane_out, lane_if.valid_out, lane_if.active};

  task automatic tick(input logic b);
    lane_if.data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) tick(w[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lane_if.data_in = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== 34'h0) begin
        n_bad++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", c, obs, 34'h0);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_lock_data();
    logic [31:0] words [2];
    logic [31:0] pl;
    logic        pv;
    words[0] = 32'hFFFFFFFF;
    words[1] = 32'hEEEEEEEE;
    do_reset();
    tick(1'b1); tick(1'b0); tick(1'b1);
    for (int k = 0; k < 4; k++) begin
      send_word(COM);
      n_cmp++;
      if (obs !== {32'h0, 1'b0, (k == 3)}) begin
        n_bad++;
        $display("FAIL lock_com%0d: got %h expected %h", k, obs, {32'h0, 1'b0, (k == 3)});
      end
    end
    pl = 32'h0;
    pv = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 31; i >= 0; i--) begin
        tick(words[n][i]);
        if (i != 0) begin
          n_cmp++;
          if (obs !== {pl, pv, 1'b1}) begin
            n_bad++;
            $display("FAIL lock_hold w%0d bit%0d: got %h expected %h", n, i, obs, {pl, pv, 1'b1});
          end
        end
      end
      n_cmp++;
      if (obs !== {words[n], 1'b1, 1'b1}) begin
        n_bad++;
        $display("FAIL lock_data w%0d: got %h expected %h", n, obs, {words[n], 1'b1, 1'b1});
      end
      pl = words[n];
      pv = 1'b1;
    end
  endtask

  task automatic test_filter();
    logic [31:0] words [6];
    logic [31:0] el    [6];
    logic        ev    [6];
    logic [31:0] pl;
    logic        pv;
    words[0] = 32'hDDDDDDDD; el[0] = 32'hDDDDDDDD; ev[0] = 1'b1;
    words[1] = IDLE;         el[1] = 32'hDDDDDDDD; ev[1] = 1'b0;
    words[2] = COM;          el[2] = 32'hDDDDDDDD; ev[2] = 1'b0;
    words[3] = 32'hCCCCCCCC; el[3] = 32'hCCCCCCCC; ev[3] = 1'b1;
    // A COM pattern straddling the boundary between these two must be ignored.
    words[4] = 32'h00BCBCBC; el[4] = 32'h00BCBCBC; ev[4] = 1'b1;
    words[5] = 32'hBC000001; el[5] = 32'hBC000001; ev[5] = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) send_word(COM);
    n_cmp++;
    if (obs !== {32'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL filter_lock: got %h expected %h", obs, {32'h0, 1'b0, 1'b1});
    end
    pl = 32'h0;
    pv = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 31; i >= 0; i--) begin
        tick(words[n][i]);
        if (i != 0) begin
          n_cmp++;
          if (obs !== {pl, pv, 1'b1}) begin
            n_bad++;
            $display("FAIL filter_hold w%0d bit%0d: got %h expected %h", n, i, obs, {pl, pv, 1'b1});
          end
        end
      end
      n_cmp++;
      if (obs !== {el[n], ev[n], 1'b1}) begin
        n_bad++;
        $display("FAIL filter_word w%0d: got %h expected %h", n, obs, {el[n], ev[n], 1'b1});
      end
      pl = el[n];
      pv = ev[n];
    end
  endtask

  task automatic test_broken_lock();
    logic [31:0] pre [3];
    pre[0] = COM;
    pre[1] = COM;
    pre[2] = 32'h00000003;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_word(pre[k]);
      n_cmp++;
      if (obs !== 34'h0) begin
        n_bad++;
        $display("FAIL broken_pre w%0d: got %h expected %h", k, obs, 34'h0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      send_word(COM);
      n_cmp++;
      if (obs !== {32'h0, 1'b0, (k == 3)}) begin
        n_bad++;
        $display("FAIL broken_relock com%0d: got %h expected %h", k, obs, {32'h0, 1'b0, (k == 3)});
      end
    end
    send_word(32'h00000004);
    n_cmp++;
    if (obs !== {32'h00000004, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL broken_data: got %h expected %h", obs, {32'h00000004, 1'b1, 1'b1});
    end
  endtask

  task automatic test_bit_offset();
    logic [16:0] g;
    g = 17'h15555;
    do_reset();
    for (int i = 16; i >= 0; i--) tick(g[i]);
    n_cmp++;
    if (obs !== 34'h0) begin
      n_bad++;
      $display("FAIL offset_garbage: got %h expected %h", obs, 34'h0);
    end
    for (int k = 0; k < 4; k++) begin
      send_word(COM);
      n_cmp++;
      if (obs !== {32'h0, 1'b0, (k == 3)}) begin
        n_bad++;
        $display("FAIL offset_com%0d: got %h expected %h", k, obs, {32'h0, 1'b0, (k == 3)});
      end
    end
    send_word(32'h12345678);
    n_cmp++;
    if (obs !== {32'h12345678, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL offset_data: got %h expected %h", obs, {32'h12345678, 1'b1, 1'b1});
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] part;
    part = 32'hABCDEF01;
    do_reset();
    for (int k = 0; k < 4; k++) send_word(COM);
    send_word(32'h12345678);
    n_cmp++;
    if (obs !== {32'h12345678, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_pre: got %h expected %h", obs, {32'h12345678, 1'b1, 1'b1});
    end
    for (int i = 31; i >= 22; i--) tick(part[i]);
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    n_cmp++;
    if (obs !== 34'h0) begin
      n_bad++;
      $display("FAIL midrst_clear: got %h expected %h", obs, 34'h0);
    end
    for (int k = 0; k < 4; k++) begin
      send_word(COM);
      n_cmp++;
      if (obs !== {32'h0, 1'b0, (k == 3)}) begin
        n_bad++;
        $display("FAIL midrst_relock com%0d: got %h expected %h", k, obs, {32'h0, 1'b0, (k == 3)});
      end
    end
    send_word(32'hA5A5A5A5);
    n_cmp++;
    if (obs !== {32'hA5A5A5A5, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_data: got %h expected %h", obs, {32'hA5A5A5A5, 1'b1, 1'b1});
    end
  endtask

  initial begin
    reset = 1'b1;
    lane_if.data_in = 1'b0;
    test_reset();
    test_lock_data();
    test_filter();
    test_broken_lock();
    test_bit_offset();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
